// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the CPU memory port and
// a debug/loader port. One access at a time: IDLE -> ACCESS (strobes low for
// ACCESS_CYCLES cycles) -> DONE (one-cycle completion pulse) -> IDLE.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise
// the CPU has fixed priority over the debug port.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              Mem_DRIVE,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q;        // 0 = CPU, 1 = debug port
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              win;          // port chosen if a grant happens this cycle
  logic              load_req;     // latch the winner's request
  logic              capture;      // latch SRAM read data for the granted port

`ifdef SRAM_ARB_RR_EN
  logic              prio_q;       // port that wins the next tie (0 = CPU)

  // Round-robin winner: the tie goes to the port not granted last
  always_comb begin
    win = dbg_req;
    if (cpu_req && dbg_req) win = prio_q;
  end

  // Pointer moves away from whichever port was just granted
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)        prio_q <= 1'b0;
    else if (load_req) prio_q <= ~win;
  end
`else
  // Fixed priority winner: debug only when the CPU is not requesting
  always_comb begin
    win = ~cpu_req;
  end
`endif

  // Next-state logic for the access sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_req = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          load_req = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          capture = ~we_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request: held stable from ACCESS entry through DONE
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_req) begin
      gnt_q   <= win;
      we_q    <= win ? dbg_we    : cpu_we;
      addr_q  <= win ? dbg_addr  : cpu_addr;
      wdata_q <= win ? dbg_wdata : cpu_wdata;
    end
  end

  // Per-port read data, updated only by that port's own reads
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (capture) begin
      if (gnt_q) dbg_rdata_q <= Data_from_SRAM;
      else       cpu_rdata_q <= Data_from_SRAM;
    end
  end

  assign Mem_CE       = (state_q != ACCESS);
  assign Mem_UB       = (state_q != ACCESS);
  assign Mem_LB       = (state_q != ACCESS);
  assign Mem_OE       = ~((state_q == ACCESS) && !we_q);
  assign Mem_WE       = ~((state_q == ACCESS) &&  we_q);
  assign Mem_DRIVE    = (state_q == ACCESS) && we_q;
  assign Mem_ADDR     = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign cpu_done     = (state_q == DONE) && !gnt_q;
  assign dbg_done     = (state_q == DONE) &&  gnt_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a small SRAM model.
// A second instance with ACCESS_CYCLES=3 covers the longer-strobe case.
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        Clk, Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [19:0] cpu_addr, dbg_addr, Mem_ADDR;
  logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic        cpu_done, dbg_done;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic        Mem_DRIVE, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  // second instance (ACCESS_CYCLES = 3), CPU port only
  logic        c3_req, c3_we, c3_done, c3_ddone, c3_drive;
  logic [19:0] c3_addr, c3_maddr;
  logic [15:0] c3_rdata, c3_drdata, c3_dto, c3_dfrom;
  logic        c3_ce, c3_ub, c3_lb, c3_oe, c3_wen;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Mem_DRIVE(Mem_DRIVE),
    .Data_from_SRAM(Data_from_SRAM),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE));

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(16'h0),
    .cpu_rdata(c3_rdata), .cpu_done(c3_done),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0),
    .dbg_rdata(c3_drdata), .dbg_done(c3_ddone),
    .Mem_ADDR(c3_maddr), .Data_to_SRAM(c3_dto), .Mem_DRIVE(c3_drive),
    .Data_from_SRAM(c3_dfrom),
    .Mem_CE(c3_ce), .Mem_UB(c3_ub), .Mem_LB(c3_lb), .Mem_OE(c3_oe), .Mem_WE(c3_wen));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM model: 16 words indexed by the low address bits
  logic [15:0] mem [16];
  always @(posedge Clk) if (!Mem_CE && !Mem_WE) mem[Mem_ADDR[3:0]] <= Data_to_SRAM;
  assign Data_from_SRAM = Mem_OE ? 16'h0 : mem[Mem_ADDR[3:0]];
  assign c3_dfrom       = c3_oe  ? 16'h0 : 16'hC3C3;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: tracks the strobe run of the current access, checks it on done
  int          run_len, run_oe, run_we, run_drive;
  logic        run_both, run_addr_bad;
  logic [19:0] run_addr;
  logic [15:0] run_data;
  exp_t        me;

  always @(negedge Clk) begin
    if (!Reset) begin
      run_len = 0; run_oe = 0; run_we = 0; run_drive = 0;
      run_both = 1'b0; run_addr_bad = 1'b0;
    end else begin
      if (!Mem_CE) begin
        if (run_len == 0) run_addr = Mem_ADDR;
        else if (Mem_ADDR !== run_addr) run_addr_bad = 1'b1;
        run_len++;
        if (!Mem_OE) run_oe++;
        if (!Mem_WE) run_we++;
        if (!Mem_OE && !Mem_WE) run_both = 1'b1;
        if (Mem_DRIVE) begin run_drive++; run_data = Data_to_SRAM; end
      end
      if (cpu_done || dbg_done) begin
        chk("single_done", {31'b0, cpu_done && dbg_done}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'b0, dbg_done, cpu_done}, 0);
        end else begin
          me = sb.pop_front();
          chk("done_port", {31'b0, dbg_done}, {31'b0, me.port});
          if (me.cyc >= 0) chk("done_cycle", cyc, me.cyc);
          chk("strobe_len", run_len, AC);
          chk("strobe_addr", {12'b0, run_addr}, {12'b0, me.addr});
          chk("addr_stable", {31'b0, run_addr_bad}, 0);
          chk("addr_hold_done", {12'b0, Mem_ADDR}, {12'b0, me.addr});
          chk("oe_we_overlap", {31'b0, run_both}, 0);
          chk("drive_in_done", {31'b0, Mem_DRIVE}, 0);
          if (me.we) begin
            chk("we_len", run_we, AC);
            chk("oe_len_wr", run_oe, 0);
            chk("drive_len", run_drive, AC);
            chk("wdata", {16'b0, run_data}, {16'b0, me.wdata});
          end else begin
            chk("oe_len", run_oe, AC);
            chk("we_len_rd", run_we, 0);
            chk("drive_len_rd", run_drive, 0);
            chk("rdata", {16'b0, (me.port ? dbg_rdata : cpu_rdata)}, {16'b0, me.rdata});
          end
        end
        run_len = 0; run_oe = 0; run_we = 0; run_drive = 0;
        run_both = 1'b0; run_addr_bad = 1'b0;
      end
    end
  end

  task automatic wait_dones(input int n, input int lim);
    int got = 0;
    for (int i = 0; i < lim && got < n; i++) begin
      @(negedge Clk);
      if (cpu_done || dbg_done) got++;
    end
    chk("done_count", got, n);
  endtask

  task automatic do_access(input logic port, input logic we, input logic [19:0] a,
                           input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    @(posedge Clk); #1;
    if (port) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    e = '{port: port, we: we, addr: a, wdata: wd, rdata: rd, cyc: cyc + AC + 1};
    sb.push_back(e);
    wait_dones(1, 20);
    cpu_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_CE"},    {31'b0, Mem_CE}, 1);
    chk({tag, "_UBLB"},  {30'b0, Mem_UB, Mem_LB}, 3);
    chk({tag, "_OE"},    {31'b0, Mem_OE}, 1);
    chk({tag, "_WE"},    {31'b0, Mem_WE}, 1);
    chk({tag, "_DRIVE"}, {31'b0, Mem_DRIVE}, 0);
    chk({tag, "_done"},  {30'b0, cpu_done, dbg_done}, 0);
    chk({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 0);
    chk({tag, "_addr"},  {12'b0, Mem_ADDR}, 0);
    chk({tag, "_wdata"}, {16'b0, Data_to_SRAM}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   c, n_oe, n_ce, n_done, done_at;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[4'h0] = 16'h1234;   // 0x00010
    mem[4'h1] = 16'h1111;   // 0x00111
    mem[4'h2] = 16'h2222;   // 0x00222
    Reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0;

    // reset state
    #12;
    chk_reset_outputs("rst");
    @(posedge Clk); #1 Reset = 1'b1;

    // CPU read, DBG write, CPU read-back, DBG read
    do_access(1'b0, 1'b0, 20'h00010, 16'h0,    16'h1234);
    do_access(1'b1, 1'b1, 20'h0ABCD, 16'hBEEF, 16'h0);
    do_access(1'b0, 1'b0, 20'h0ABCD, 16'h0,    16'hBEEF);
    chk("dbg_rdata_untouched", {16'b0, dbg_rdata}, 0);
    do_access(1'b1, 1'b0, 20'h00010, 16'h0,    16'h1234);
    chk("cpu_rdata_held", {16'b0, cpu_rdata}, 16'hBEEF);

    // both ports requesting continuously for four accesses
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00111;
    dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00222;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      if (i % 2 == 0) e = '{port: 1'b0, we: 1'b0, addr: 20'h00111, wdata: 16'h0, rdata: 16'h1111, cyc: c + 3 + 4 * i};
      else            e = '{port: 1'b1, we: 1'b0, addr: 20'h00222, wdata: 16'h0, rdata: 16'h2222, cyc: c + 3 + 4 * i};
`else
      e = '{port: 1'b0, we: 1'b0, addr: 20'h00111, wdata: 16'h0, rdata: 16'h1111, cyc: c + 3 + 4 * i};
`endif
      sb.push_back(e);
    end
    wait_dones(4, 40);
    cpu_req = 0; dbg_req = 0;
`ifndef SRAM_ARB_RR_EN
    chk("dbg_starved_rdata", {16'b0, dbg_rdata}, 16'h1234);
`endif

    // asynchronous reset during the second ACCESS cycle of a write
    @(posedge Clk); #1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 20'h00205; dbg_wdata = 16'h5555;
    @(posedge Clk);
    @(posedge Clk); #2;
    chk("pre_reset_WE_low", {31'b0, Mem_WE}, 0);
    Reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    dbg_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    @(posedge Clk); #1;
    Reset = 1'b1;
    e = '{port: 1'b0, we: 1'b0, addr: 20'h00010, wdata: 16'h0, rdata: 16'h1234, cyc: cyc + AC + 1};
    sb.push_back(e);
    wait_dones(1, 20);
    cpu_req = 0;

    // ACCESS_CYCLES=3 instance, request dropped one cycle after grant
    @(posedge Clk); #1;
    c3_req = 1; c3_we = 0; c3_addr = 20'h00030;
    c = cyc;
    @(posedge Clk); #1;
    c3_req = 0;
    n_oe = 0; n_ce = 0; n_done = 0; done_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (!c3_oe) n_oe++;
      if (!c3_ce) n_ce++;
      if (c3_done) begin n_done++; done_at = cyc; end
      if (c3_ddone) n_done += 100;
    end
    chk("ac3_oe_len", n_oe, 3);
    chk("ac3_ce_len", n_ce, 3);
    chk("ac3_done_count", n_done, 1);
    chk("ac3_done_cycle", done_at, c + 4);
    chk("ac3_rdata", {16'b0, c3_rdata}, 16'hC3C3);
    chk("ac3_addr_held", {12'b0, c3_maddr}, 20'h00030);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
